// File: rtl/vco_pkg.sv
// Shared widths and fixed-point helpers for the multi-channel symplectic VCO.
// All helpers work on 64-bit signed values; callers slice results back to W.
package vco_pkg;

    function automatic int w2_width(input int u_w, input int u_shift);
        return 2 * u_w - u_shift;
    endfunction

    function automatic int acc_width(input int w, input int w2_w);
        return w + w2_w + 1;
    endfunction

    function automatic int slot_width(input int nch);
        return (nch < 2) ? 1 : $clog2(nch);
    endfunction

    // Arithmetic right shift: rounds toward minus infinity (floor).
    function automatic logic signed [63:0] asr(input logic signed [63:0] val, input int sh);
        return val >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_w(input logic signed [63:0] val, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (val > hi) begin
            return hi;
        end
        if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/vco_euler_step.sv
// One semi-implicit Euler step of a fixed-point harmonic oscillator.
// Purely combinational; the new velocity feeds the position update.
module vco_euler_step
    import vco_pkg::*;
#(
    parameter int U_W      = 10,
    parameter int W        = 12,
    parameter int U_SHIFT  = 10,
    parameter int A_SHIFT  = 11,
    parameter int DT_SHIFT = 3
) (
    input  logic [U_W-1:0]        i_u,
    input  logic signed [W-1:0]   i_x,
    input  logic signed [W-1:0]   i_v,
    output logic signed [W-1:0]   o_x,
    output logic signed [W-1:0]   o_v,
    output logic                  o_sat
);

    localparam int W2_W  = w2_width(U_W, U_SHIFT);
    localparam int ACC_W = acc_width(W, W2_W);

    logic [2*U_W-1:0]          w_uu;
    logic [W2_W-1:0]           w_w2;
    logic signed [ACC_W-1:0]   w_prod;
    logic signed [63:0]        w_acc;
    logic signed [63:0]        w_v_sum;
    logic signed [63:0]        w_v_sat;
    logic signed [63:0]        w_x_sum;
    logic signed [63:0]        w_x_sat;

    assign w_uu   = {{U_W{1'b0}}, i_u} * {{U_W{1'b0}}, i_u};
    assign w_w2   = W2_W'(w_uu >> U_SHIFT);
    // w2 is unsigned, so it gets a zero sign bit before the signed multiply.
    assign w_prod = ACC_W'($signed({1'b0, w_w2})) * ACC_W'(i_x);

    assign w_acc   = -asr(64'(w_prod), A_SHIFT);
    assign w_v_sum = 64'(i_v) + asr(w_acc, DT_SHIFT);
    assign w_v_sat = sat_w(w_v_sum, W);
    assign w_x_sum = 64'(i_x) + asr(w_v_sat, DT_SHIFT);
    assign w_x_sat = sat_w(w_x_sum, W);

    assign o_v   = w_v_sat[W-1:0];
    assign o_x   = w_x_sat[W-1:0];
    assign o_sat = (w_v_sat != w_v_sum) || (w_x_sat != w_x_sum);

endmodule

// File: rtl/vco_multi_symplectic.sv
// N-channel time-multiplexed VCO: per-channel x/v state, round-robin slot,
// restart handling, rising-crossing pulses and sticky saturation flags.
module vco_multi_symplectic
    import vco_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int U_W      = 10,
    parameter int W        = 12,
    parameter int U_SHIFT  = 10,
    parameter int A_SHIFT  = 11,
    parameter int DT_SHIFT = 3,
    parameter int X_INIT   = 1024,
    localparam int SLOT_W  = slot_width(NCH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NCH*U_W-1:0]    ctrl_voltage,
    input  logic [NCH-1:0]        restart,
    output logic [NCH*W-1:0]      x_out,
    output logic [NCH-1:0]        clk_out,
    output logic [NCH-1:0]        rise_pulse,
    output logic [NCH-1:0]        sat_flag,
    output logic [SLOT_W-1:0]     slot
);

    localparam logic signed [W-1:0] X_RST = W'(X_INIT);

    logic signed [W-1:0]  r_x [NCH];
    logic signed [W-1:0]  r_v [NCH];
    logic [SLOT_W-1:0]    r_slot;
    logic [NCH-1:0]       r_rise;
    logic [NCH-1:0]       r_sat;

    logic [U_W-1:0]       w_u;
    logic signed [W-1:0]  w_x_cur;
    logic signed [W-1:0]  w_v_cur;
    logic signed [W-1:0]  w_x_nxt;
    logic signed [W-1:0]  w_v_nxt;
    logic                 w_sat_step;
    logic                 w_rise_step;
    logic [SLOT_W-1:0]    w_slot_nxt;

    assign w_u     = ctrl_voltage[r_slot*U_W +: U_W];
    assign w_x_cur = r_x[r_slot];
    assign w_v_cur = r_v[r_slot];

    vco_euler_step #(
        .U_W      (U_W),
        .W        (W),
        .U_SHIFT  (U_SHIFT),
        .A_SHIFT  (A_SHIFT),
        .DT_SHIFT (DT_SHIFT)
    ) u_step (
        .i_u   (w_u),
        .i_x   (w_x_cur),
        .i_v   (w_v_cur),
        .o_x   (w_x_nxt),
        .o_v   (w_v_nxt),
        .o_sat (w_sat_step)
    );

    assign w_rise_step = w_x_cur[W-1] & ~w_x_nxt[W-1];
    assign w_slot_nxt  = (r_slot == SLOT_W'(NCH - 1)) ? '0 : r_slot + SLOT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot <= '0;
            r_rise <= '0;
            r_sat  <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_x[c] <= X_RST;
                r_v[c] <= '0;
            end
        end else begin
            r_rise <= '0;
            if (en) begin
                r_slot         <= w_slot_nxt;
                r_x[r_slot]    <= w_x_nxt;
                r_v[r_slot]    <= w_v_nxt;
                r_rise[r_slot] <= w_rise_step;
                if (w_sat_step) begin
                    r_sat[r_slot] <= 1'b1;
                end
            end
            // Restart is applied last so it wins over a coincident step.
            for (int c = 0; c < NCH; c++) begin
                if (restart[c]) begin
                    r_x[c]    <= X_RST;
                    r_v[c]    <= '0;
                    r_sat[c]  <= 1'b0;
                    r_rise[c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        x_out   = '0;
        clk_out = '0;
        for (int c = 0; c < NCH; c++) begin
            x_out[c*W +: W] = r_x[c];
            clk_out[c]      = ~r_x[c][W-1];
        end
    end

    assign rise_pulse = r_rise;
    assign sat_flag   = r_sat;
    assign slot       = r_slot;

endmodule

// File: tb/tb_vco_multi_symplectic.sv
// Scoreboard bench: stimulus queues expected values per cycle, a negedge monitor
// pops and compares them against three DUT instances.
module tb_vco_multi_symplectic;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 4 channels, default shifts
    logic        en_a;
    logic [39:0] ctrl_a;
    logic [3:0]  restart_a;
    logic [47:0] x_a;
    logic [3:0]  clko_a, rise_a, sat_a;
    logic [1:0]  slot_a;
    // B: 1 channel, default shifts
    logic        en_b;
    logic [9:0]  ctrl_b;
    logic [0:0]  restart_b;
    logic [11:0] x_b;
    logic [0:0]  clko_b, rise_b, sat_b, slot_b;
    // C: 1 channel, no acceleration/time-step shift (forces saturation)
    logic        en_c;
    logic [9:0]  ctrl_c;
    logic [0:0]  restart_c;
    logic [11:0] x_c;
    logic [0:0]  clko_c, rise_c, sat_c, slot_c;

    vco_multi_symplectic #(.NCH(4)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .ctrl_voltage(ctrl_a), .restart(restart_a),
        .x_out(x_a), .clk_out(clko_a), .rise_pulse(rise_a), .sat_flag(sat_a), .slot(slot_a));

    vco_multi_symplectic #(.NCH(1)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .ctrl_voltage(ctrl_b), .restart(restart_b),
        .x_out(x_b), .clk_out(clko_b), .rise_pulse(rise_b), .sat_flag(sat_b), .slot(slot_b));

    vco_multi_symplectic #(.NCH(1), .A_SHIFT(0), .DT_SHIFT(0)) dut_c (
        .clk(clk), .reset(reset), .en(en_c), .ctrl_voltage(ctrl_c), .restart(restart_c),
        .x_out(x_c), .clk_out(clko_c), .rise_pulse(rise_c), .sat_flag(sat_c), .slot(slot_c));

    typedef struct {
        int     cyc;
        int     sig;
        longint exp;
        string  name;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit     osc_on = 1'b0;
    longint peak = 0;
    int     rise_cnt = 0;
    int     tog_cnt = 0;
    logic   prev_clk_b = 1'b1;

    function automatic longint get_sig(input int s);
        case (s)
            0:  return longint'($signed(x_a[11:0]));
            1:  return longint'($signed(x_a[23:12]));
            2:  return longint'($signed(x_a[35:24]));
            3:  return longint'($signed(x_a[47:36]));
            4:  return longint'(clko_a);
            5:  return longint'(sat_a);
            6:  return longint'(slot_a);
            7:  return longint'(rise_a);
            8:  return longint'($signed(x_b));
            9:  return longint'(rise_b);
            10: return longint'(sat_b);
            11: return longint'(clko_b);
            12: return longint'(slot_b);
            13: return longint'($signed(x_c));
            14: return longint'(sat_c);
            15: return longint'(clko_c);
            16: return longint'(rise_c);
            17: return longint'(slot_c);
            20: return (peak >= 992 && peak <= 1056) ? 64'sd1 : 64'sd0;
            21: return longint'(rise_cnt);
            22: return longint'(tog_cnt);
            default: return -64'sd1;
        endcase
    endfunction

    always @(negedge clk) begin
        longint ax;
        chk_t   e;
        longint act;
        if (osc_on) begin
            ax = longint'($signed(x_b));
            if (ax < 0) ax = -ax;
            if (ax > peak) peak = ax;
            if (rise_b[0]) rise_cnt++;
            if (clko_b[0] != prev_clk_b) tog_cnt++;
        end
        prev_clk_b = clko_b[0];
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            act = get_sig(e.sig);
            checks++;
            if (e.cyc != cyc || act != e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d (due %0d): got %0d expected %0d",
                         e.name, cyc, e.cyc, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int s, input longint v, input string nm);
        chk_t e;
        e.cyc  = cyc;
        e.sig  = s;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    function automatic longint clamp12(input longint v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Independent integer model of one step with default widths.
    task automatic mstep(input longint u, input longint x, input longint v,
                         input int ash, input int dsh,
                         output longint xn, output longint vn, output bit s);
        longint w2, a, vs, xs;
        w2 = (u * u) >>> 10;
        a  = -((w2 * x) >>> ash);
        vs = v + (a >>> dsh);
        vn = clamp12(vs);
        xs = x + (vn >>> dsh);
        xn = clamp12(xs);
        s  = (vn != vs) || (xn != xs);
    endtask

    initial begin
        int     exp_x0 [18];
        longint mx, mv, nx, nv;
        bit     ms, msat;
        int     m_rise, m_tog;

        en_a = 0; ctrl_a = '0; restart_a = '0;
        en_b = 0; ctrl_b = '0; restart_b = '0;
        en_c = 0; ctrl_c = '0; restart_c = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        for (int c = 0; c < 4; c++) expect_now(c, 1024, "reset_x_a");
        expect_now(4, 15, "reset_clk_a");
        expect_now(5, 0, "reset_sat_a");
        expect_now(6, 0, "reset_slot_a");
        expect_now(7, 0, "reset_rise_a");
        expect_now(8, 1024, "reset_x_b");
        expect_now(11, 1, "reset_clk_b");
        expect_now(12, 0, "reset_slot_b");
        expect_now(13, 1024, "reset_x_c");
        expect_now(15, 1, "reset_clk_c");
        expect_now(17, 0, "reset_slot_c");

        // Idle with a live control voltage: nothing may move.
        ctrl_a = 40'd1023;
        repeat (20) tick();
        for (int c = 0; c < 4; c++) expect_now(c, 1024, "idle_x_a");
        expect_now(6, 0, "idle_slot_a");
        expect_now(5, 0, "idle_sat_a");

        // Zero drive.
        ctrl_a = '0;
        en_a = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            expect_now(6, k % 4, "zero_slot_a");
            expect_now(7, 0, "zero_rise_a");
        end
        for (int c = 0; c < 4; c++) expect_now(c, 1024, "zero_x_a");
        expect_now(4, 15, "zero_clk_a");

        // Round robin: only channel 0 driven; restart coincident with slot 0 at edge 13.
        exp_x0[1] = 1016; exp_x0[2] = 1016; exp_x0[3] = 1016; exp_x0[4] = 1016;
        exp_x0[5] = 1000; exp_x0[6] = 1000; exp_x0[7] = 1000; exp_x0[8] = 1000;
        exp_x0[9] = 976;  exp_x0[10] = 976; exp_x0[11] = 976; exp_x0[12] = 976;
        exp_x0[13] = 1024; exp_x0[14] = 1024; exp_x0[15] = 1024; exp_x0[16] = 1024;
        exp_x0[17] = 1016;
        ctrl_a = 40'd1023;
        for (int k = 1; k <= 17; k++) begin
            restart_a = (k == 13) ? 4'b0001 : 4'b0000;
            tick();
            expect_now(0, exp_x0[k], "rr_x0");
            expect_now(1, 1024, "rr_x1");
            expect_now(6, k % 4, "rr_slot");
            expect_now(5, 0, "rr_sat");
        end
        expect_now(2, 1024, "rr_x2");
        expect_now(3, 1024, "rr_x3");
        restart_a = '0;
        en_a = 1'b0;

        // Oscillation on single-channel instance.
        ctrl_b = 10'd1023;
        en_b = 1'b1;
        mx = 1024; mv = 0; msat = 0; m_rise = 0; m_tog = 0;
        osc_on = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            mstep(1023, mx, mv, 11, 3, nx, nv, ms);
            if (mx < 0 && nx >= 0) m_rise++;
            if ((mx < 0) != (nx < 0)) m_tog++;
            expect_now(0, 0, "");
            void'(sb.pop_back());
            tick();
            expect_now(8, nx, "osc_x_b");
            expect_now(9, (mx < 0 && nx >= 0) ? 1 : 0, "osc_rise_b");
            msat = msat | ms;
            expect_now(10, msat ? 1 : 0, "osc_sat_b");
            expect_now(11, (nx >= 0) ? 1 : 0, "osc_clk_b");
            if (k == 1) expect_now(8, 1016, "first_step_x");
            if (k == 2) expect_now(8, 1000, "second_step_x");
            mx = nx;
            mv = nv;
        end
        en_b = 1'b0;
        tick();
        osc_on = 1'b0;
        expect_now(20, 1, "osc_peak_in_bound");
        expect_now(21, m_rise, "osc_rise_count");
        expect_now(22, m_tog, "osc_clk_toggles");
        expect_now(10, 0, "osc_sat_clear");

        // Saturation then restart with en=1 at slot 0.
        ctrl_c = 10'd1023;
        en_c = 1'b1;
        tick();
        expect_now(13, -1024, "sat_x_c");
        expect_now(14, 1, "sat_flag_c");
        expect_now(15, 0, "sat_clk_c");
        expect_now(16, 0, "sat_rise_c");
        restart_c = 1'b1;
        tick();
        expect_now(13, 1024, "restart_x_c");
        expect_now(14, 0, "restart_sat_c");
        expect_now(15, 1, "restart_clk_c");
        expect_now(16, 0, "restart_rise_c");
        expect_now(17, 0, "restart_slot_c");
        restart_c = 1'b0;
        tick();
        expect_now(13, -1024, "resat_x_c");
        expect_now(14, 1, "resat_flag_c");
        en_c = 1'b0;
        tick();
        expect_now(13, -1024, "hold_x_c");
        expect_now(14, 1, "hold_sat_c");

        repeat (3) tick();
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
            errors += sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vco_multi_symplectic.md
Name: vco_multi_symplectic

Overview:
- Parametrised, N-channel successor to the single-channel PLL voltage-controlled oscillator.
- Each channel is a fixed-point harmonic oscillator. Its angular-frequency² term comes from the channel's control voltage.
- Integration is semi-implicit (symplectic) Euler, so amplitude does not drift.
- Channels are time-multiplexed round-robin through one shared step datapath.
- Each channel also produces a square-wave clock, a rising-edge pulse and a saturation flag for the PLL phase detector and benches.

Parameters:
- NCH, 4, number of oscillator channels (1..16).
- U_W, 10, control-voltage width (unsigned).
- W, 12, state width of x and v (signed two's complement).
- U_SHIFT, 10, right shift applied to u*u to form w2.
- A_SHIFT, 11, right shift applied to w2*x to form acceleration.
- DT_SHIFT, 3, time-step shift (dt = 2^-DT_SHIFT).
- X_INIT, 1024, initial/restart value of x (signed, fits W).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- en  in  1  advance round-robin and perform updates.
- ctrl_voltage  in  NCH*U_W  per-channel unsigned control voltage; channel c at [c*U_W +: U_W].
- restart  in  NCH  per-channel re-initialise request.
- x_out  out  NCH*W  per-channel signed x state, packed as ctrl_voltage.
- clk_out  out  NCH  per-channel square clock, equal to ~x[W-1].
- rise_pulse  out  NCH  one-cycle pulse on a negative-to-non-negative crossing of x.
- sat_flag  out  NCH  sticky; set when any clamp occurred on that channel.
- slot  out  clog2(max(NCH,2))  channel index to be updated at the next enabled edge.

Behaviour:
- Reset values:
  - x[c]=X_INIT, v[c]=0 for every channel.
  - slot=0.
  - rise_pulse=0, sat_flag=0.
  - clk_out=1 if X_INIT>=0, else 0.
- Slot counter:
  - On each edge with en=1, slot advances 0..NCH-1 and wraps to 0.
  - With en=0 the slot holds, and no state, pulse or flag changes except restart.
  - With NCH=1, slot stays 0 and channel 0 updates every enabled cycle.
- Step for channel c=slot. All arithmetic is full width with no intermediate truncation; >>> is arithmetic, i.e. floor.
  - w2 = (u*u) >> U_SHIFT, unsigned.
  - a = -((w2 * x) >>> A_SHIFT), signed, computed from the old x.
  - v' = sat(v + (a >>> DT_SHIFT)).
  - x' = sat(x + (v' >>> DT_SHIFT)). Using the new v' is what makes the update symplectic.
  - sat() clamps to [-2^(W-1), 2^(W-1)-1].
- Commit: x[c], v[c] load x', v' on the edge.
  - If either clamp was active, sat_flag[c] sets on the same edge.
- rise_pulse[c]:
  - Registered; high for exactly the one cycle after an update where old x<0 and x'>=0.
  - Low in all other cycles.
- Latency:
  - A control-voltage change affects channel c at its next slot, i.e. within NCH cycles.
  - x_out, clk_out and rise_pulse reflect a step one edge after commit.
- restart[c]=1 on an edge:
  - Sets x[c]=X_INIT, v[c]=0, sat_flag[c]=0, rise_pulse[c]=0.
  - Applies regardless of en or slot, and overrides a coincident step on c.
  - The slot counter is unaffected.
  - Multiple channels may restart simultaneously.
- reset has priority over restart and en.
- Outputs are driven directly from state registers, so they are glitch-free.

Decomposition:
- Shared package vco_pkg holds:
  - derived widths: W2_W=2*U_W-U_SHIFT, ACC_W=W+W2_W+1, SLOT_W;
  - a saturate-to-W function;
  - the floor-shift convention.
- One natural sub-module, vco_euler_step: purely combinational step (u, x, v) -> (x', v', sat).
- The top holds the state arrays, slot counter, restart logic and edge detection.

Test Plan:
- Reset then idle: after reset, every x_out=1024, clk_out=1111, sat_flag=0, slot=0. With en=0 for 20 cycles nothing changes.
- Zero drive, u=0 on all channels, en=1 for 100 cycles: w2=0, so every x_out stays 1024 and no rise_pulse fires.
- First step, NCH=1, u=1023, one enabled edge:
  - w2=1022, a=-511, v'=-64, x'=1016.
  - Next edge: v=-128, x=1000.
- Round robin, NCH=4, u0=1023, others 0, en=1:
  - Only channel 0 changes, once every 4 cycles.
  - x0 goes 1024 → 1016 at the first edge, then next changes on the fifth edge.
- Oscillation and edge, NCH=1, u=1023, run 2000 cycles:
  - clk_out toggles; rise_pulse is a single cycle at each x crossing ≥0.
  - Peak |x| stays within 1024±32 (symplectic bound); sat_flag stays 0.
- Saturation and restart, instance A_SHIFT=0, DT_SHIFT=0, u=1023:
  - First step clamps v to -2048 and sets sat_flag.
  - Pulsing restart[0] restores x=1024, v=0, sat_flag=0 on the next edge, even with en=1 and slot=0 coincident.
